// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC generator and its deserializer.
package crc_pkg;

  localparam int unsigned LFSR_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit counter must hold the values 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(LFSR_WIDTH_DEF);

endpackage

// File: rtl/crc_deserializer.sv
// Collects an LSB-first serial CRC into a parallel word behind a one-entry
// valid/ready register, and counts words that differ from the expected CRC.
module crc_deserializer
  import crc_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH    = LFSR_WIDTH_DEF,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CRC_IN,
  input  logic                     VALID_IN,
  input  logic [LFSR_WIDTH-1:0]    EXP_CRC,
  output logic [LFSR_WIDTH-1:0]    OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     MATCH,
  output logic                     ERR_SHORT,
  output logic                     OVERRUN,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT
);

  localparam int unsigned CNT_W = cnt_width(LFSR_WIDTH);
  localparam int unsigned SH_W  = LFSR_WIDTH - 1;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [SH_W-1:0]          shreg_q, shreg_d;
  logic [LFSR_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     match_q, match_d;
  logic                     err_short_q, err_short_d;
  logic                     overrun_q, overrun_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     complete_c;
  logic                     word_match_c;
  logic [LFSR_WIDTH-1:0]    word_c;

  // Next-state: bit assembly, then output register / handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    valid_d      = valid_q;
    match_d      = match_q;
    err_short_d  = 1'b0;
    overrun_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    complete_c   = 1'b0;
    word_c       = {CRC_IN, shreg_q};
    word_match_c = (word_c == EXP_CRC);

    case (state_q)
      IDLE: begin
        if (VALID_IN) begin
          shreg_d[0] = CRC_IN;
          cnt_d      = CNT_W'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (VALID_IN) begin
          if (cnt_q == CNT_W'(LFSR_WIDTH - 1)) begin
            // Last bit bypasses the shift register straight into the word.
            complete_c = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            for (int unsigned i = 0; i < SH_W; i++) begin
              if (cnt_q == CNT_W'(i)) shreg_d[i] = CRC_IN;
            end
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          err_short_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && OUT_READY) valid_d = 1'b0;

    if (complete_c) begin
      if (!valid_q || OUT_READY) begin
        data_d  = word_c;
        match_d = word_match_c;
        valid_d = 1'b1;
        if (!word_match_c && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      match_q     <= 1'b0;
      err_short_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      match_q     <= match_d;
      err_short_q <= err_short_d;
      overrun_q   <= overrun_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign OUT_DATA  = data_q;
  assign OUT_VALID = valid_q;
  assign MATCH     = match_q;
  assign ERR_SHORT = err_short_q;
  assign OVERRUN   = overrun_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: doc/crc_deserializer.md
Name: crc_deserializer

Overview:
Downstream stage of the serial CRC generator. Consumes the generator's serial CRC bitstream (CRC, Valid), which arrives LSB first for LFSR_WIDTH consecutive cycles. Assembles the bits into a parallel word and presents it through a one-entry valid/ready output register. Also compares the word against an expected value and keeps a saturating mismatch count for self-checking links and bring-up.

Parameters:
LFSR_WIDTH, 8, CRC width in bits; equals the number of serial bits per frame.
ERR_CNT_WIDTH, 8, width of the saturating mismatch counter.

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-low reset
CRC_IN  input  1  serial CRC bit from generator, LSB first
VALID_IN  input  1  high while CRC_IN carries a valid frame bit
EXP_CRC  input  LFSR_WIDTH  expected CRC, sampled on the frame-completion edge
OUT_DATA  output  LFSR_WIDTH  assembled CRC word
OUT_VALID  output  1  OUT_DATA holds an unconsumed word
OUT_READY  input  1  consumer accepts the word when OUT_VALID & OUT_READY
MATCH  output  1  OUT_DATA == EXP_CRC; qualified by OUT_VALID
ERR_SHORT  output  1  one-cycle pulse: VALID_IN dropped mid-frame
OVERRUN  output  1  one-cycle pulse: completed frame dropped because the output register was full
ERR_CNT  output  ERR_CNT_WIDTH  saturating count of frames with MATCH=0

Behaviour:
- Reset (RST=0, asynchronous): FSM=IDLE, bit counter=0, shift register=0. Outputs: OUT_DATA=0, OUT_VALID=0, MATCH=0, ERR_SHORT=0, OVERRUN=0, ERR_CNT=0. Reset mid-frame discards the partial frame and any held word.
- FSM states: IDLE, SHIFT.
- IDLE:
  - Edge with VALID_IN=1: shreg[0] <= CRC_IN, cnt <= 1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Edge with VALID_IN=1: shreg[cnt] <= CRC_IN, cnt <= cnt+1.
  - When the bit written is index LFSR_WIDTH-1, that edge is the completion edge: go to IDLE, cnt <= 0.
  - Edge with VALID_IN=0 and cnt<LFSR_WIDTH: abort. ERR_SHORT=1 for one cycle, go to IDLE, cnt <= 0, nothing output, ERR_CNT unchanged.
- Completion word = {CRC_IN, shreg[LFSR_WIDTH-2:0]}; the final bit goes straight into the word, with no extra cycle.
- Latency: OUT_VALID rises on the same edge that samples bit LFSR_WIDTH-1.
- Output register load at the completion edge:
  - Load if OUT_VALID=0, or if OUT_VALID & OUT_READY in the same cycle (accept and reload).
  - Load sets OUT_DATA = completion word, MATCH = (word == EXP_CRC), OUT_VALID=1.
  - Load with mismatch: ERR_CNT += 1, saturating at all-ones.
  - No load (register full, not accepted): new word dropped, OVERRUN=1 for one cycle, held word and MATCH unchanged, ERR_CNT unchanged.
- Handshake:
  - OUT_VALID stays high and OUT_DATA/MATCH stay stable until an edge with OUT_READY=1.
  - On that edge OUT_VALID clears, unless the same edge reloads.
  - OUT_READY is ignored while OUT_VALID=0.
- Back-to-back: VALID_IN held high past a completion edge starts a new frame on the next edge (IDLE sees VALID_IN=1). There are no mandatory gap cycles.
- ERR_SHORT and OVERRUN are registered pulses. They never assert together because abort and completion are mutually exclusive.
- MATCH is a don't-care when OUT_VALID=0; it is held at its last value.

Decomposition:
- Shared package crc_pkg:
  - LFSR_WIDTH default constant (shared with the CRC generator).
  - FSM state typedef {IDLE, SHIFT}.
  - Counter width constant $clog2(LFSR_WIDTH+1).
- Single module, no sub-module. The output register and handshake are small enough to stay inline.

Test Plan:
- Nominal match: reset, then VALID_IN=1 for 8 cycles with bits 1,0,1,0,0,1,0,1 (0xA5 LSB first), EXP_CRC=0xA5, OUT_READY=1 -> OUT_VALID rises on the 8th edge, OUT_DATA=0xA5, MATCH=1, ERR_CNT=0, OUT_VALID clears on the next edge.
- Mismatch/counter: send 0x3C with EXP_CRC=0x3D -> MATCH=0, ERR_CNT=1. Repeat 256 mismatching frames -> ERR_CNT saturates at 0xFF.
- Short frame: VALID_IN high 5 cycles then low -> ERR_SHORT one-cycle pulse on the 6th edge, OUT_VALID stays 0. A following full frame of 0x81 -> OUT_DATA=0x81.
- Backpressure/overrun: OUT_READY=0, send back-to-back frames 0x11 then 0x22 -> OUT_DATA stays 0x11 and OVERRUN pulses on the 16th edge. Raise OUT_READY -> 0x11 accepted, OUT_VALID=0.
- Accept-and-reload: OUT_READY asserted exactly on the completion edge of frame 0x22 while 0x11 is held -> 0x11 consumed, OUT_DATA=0x22, OUT_VALID stays 1, no OVERRUN.
- Async reset mid-frame: drop RST between clock edges after 4 bits -> all outputs 0 immediately. A full frame of 0xF0 after release -> OUT_DATA=0xF0.
